// File: rtl/bank_request_queue_if.sv
// bank_request_queue_if: upstream request channel, per-bank busy and issue bus of bank_request_queue.
`default_nettype none

interface bank_request_queue_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 3
);
  logic                    i_req_valid;
  logic                    o_req_ready;
  logic                    i_req_wr;
  logic [ADDR_WIDTH-1:0]   i_req_addr;
  logic [DATA_WIDTH-1:0]   i_req_data;
  logic [3:0]              i_bank_busy;
  logic                    o_issue_valid;
  logic [1:0]              o_issue_sel;
  logic [ADDR_WIDTH-3:0]   o_issue_addr;
  logic [DATA_WIDTH-1:0]   o_issue_data;
  logic                    o_issue_wr;
  logic [CNT_WIDTH-1:0]    o_count;
  logic                    o_full;
  logic                    o_empty;
  logic [7:0]              o_stall_cnt;

  modport slave (
    input  i_req_valid, i_req_wr, i_req_addr, i_req_data, i_bank_busy,
    output o_req_ready, o_issue_valid, o_issue_sel, o_issue_addr, o_issue_data,
           o_issue_wr, o_count, o_full, o_empty, o_stall_cnt
  );

  modport master (
    output i_req_valid, i_req_wr, i_req_addr, i_req_data, i_bank_busy,
    input  o_req_ready, o_issue_valid, o_issue_sel, o_issue_addr, o_issue_data,
           o_issue_wr, o_count, o_full, o_empty, o_stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/bank_request_queue.sv
// bank_request_queue: in-order request FIFO issuing one request per cycle to a four-bank array.
// Rev 1.0 - initial release.
`default_nettype none

module bank_request_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  bank_request_queue_if.slave   bus
);

  localparam int                   PTR_W    = $clog2(DEPTH);
  localparam int                   ENTRY_W  = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int                   LADDR_W  = ADDR_WIDTH - 2;
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

  logic [ENTRY_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  issue_valid_q, issue_valid_d;
  logic [1:0]            issue_sel_q, issue_sel_d;
  logic [LADDR_W-1:0]    issue_addr_q, issue_addr_d;
  logic [DATA_WIDTH-1:0] issue_data_q, issue_data_d;
  logic                  issue_wr_q, issue_wr_d;
  logic [7:0]            stall_q, stall_d;

  logic [ENTRY_W-1:0]    w_head;
  logic                  w_head_wr;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [1:0]            w_hsel;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_fire;

  assign w_head      = mem_q[rptr_q];
  assign w_head_wr   = w_head[ENTRY_W-1];
  assign w_head_addr = w_head[DATA_WIDTH +: ADDR_WIDTH];
  assign w_head_data = w_head[DATA_WIDTH-1:0];
  assign w_hsel      = w_head_addr[ADDR_WIDTH-1 -: 2];

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == CNT_FULL);
  assign w_push  = bus.i_req_valid && !w_full;
  // Strict head-of-line: only the head's bank is consulted, younger entries wait.
  assign w_fire  = !w_empty && !bus.i_bank_busy[w_hsel];

  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    count_d       = count_q;
    issue_valid_d = 1'b0;
    issue_sel_d   = issue_sel_q;
    issue_addr_d  = issue_addr_q;
    issue_data_d  = issue_data_q;
    issue_wr_d    = issue_wr_q;
    stall_d       = stall_q;

    if (w_push) begin
      wptr_d = wptr_q + PTR_ONE;
    end

    if (w_fire) begin
      rptr_d        = rptr_q + PTR_ONE;
      issue_valid_d = 1'b1;
      issue_sel_d   = w_hsel;
      issue_addr_d  = w_head_addr[LADDR_W-1:0];
      issue_data_d  = w_head_data;
      issue_wr_d    = w_head_wr;
      stall_d       = 8'd0;
    end else if (!w_empty && (stall_q != 8'hFF)) begin
      stall_d = stall_q + 8'd1;
    end

    if (w_push && !w_fire) begin
      count_d = count_q + CNT_ONE;
    end else if (w_fire && !w_push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_sel_q   <= '0;
      issue_addr_q  <= '0;
      issue_data_q  <= '0;
      issue_wr_q    <= 1'b0;
      stall_q       <= '0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      issue_sel_q   <= issue_sel_d;
      issue_addr_q  <= issue_addr_d;
      issue_data_q  <= issue_data_d;
      issue_wr_q    <= issue_wr_d;
      stall_q       <= stall_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      mem_q[wptr_q] <= {bus.i_req_wr, bus.i_req_addr, bus.i_req_data};
    end
  end

  assign bus.o_req_ready   = !w_full;
  assign bus.o_full        = w_full;
  assign bus.o_empty       = w_empty;
  assign bus.o_count       = count_q;
  assign bus.o_issue_valid = issue_valid_q;
  assign bus.o_issue_sel   = issue_sel_q;
  assign bus.o_issue_addr  = issue_addr_q;
  assign bus.o_issue_data  = issue_data_q;
  assign bus.o_issue_wr    = issue_wr_q;
  assign bus.o_stall_cnt   = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_bank_request_queue.sv
// tb_bank_request_queue: directed stimulus, queue-based reference model and per-cycle compare.
`default_nettype none

module tb_bank_request_queue;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic clk;
  logic rst_n;

  bank_request_queue_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  bank_request_queue #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a plain queue of pending requests plus the expected issue register.
  ent_t       mq[$];
  logic       e_valid, e_wr;
  logic [1:0] e_sel;
  logic [5:0] e_addr;
  logic [7:0] e_data;
  int         e_stall;

  task automatic model_step();
    ent_t h;
    bit   fire;
    bit   take;
    if (!rst_n) begin
      mq.delete();
      e_valid = 0; e_wr = 0; e_sel = 0; e_addr = 0; e_data = 0; e_stall = 0;
    end else begin
      fire = 0;
      take = bus.i_req_valid && (mq.size() < DEPTH);
      e_valid = 0;
      if (mq.size() > 0) begin
        h = mq[0];
        if (!bus.i_bank_busy[h.addr[7:6]]) begin
          fire = 1;
          void'(mq.pop_front());
          e_valid = 1; e_sel = h.addr[7:6]; e_addr = h.addr[5:0];
          e_data = h.data; e_wr = h.wr; e_stall = 0;
        end else if (e_stall < 255) begin
          e_stall++;
        end
      end
      if (take) begin
        h.wr = bus.i_req_wr; h.addr = bus.i_req_addr; h.data = bus.i_req_data;
        mq.push_back(h);
      end
    end
  endtask

  initial begin
    e_valid = 0; e_wr = 0; e_sel = 0; e_addr = 0; e_data = 0; e_stall = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("count", 32'(bus.o_count), 32'(mq.size()));
      chk("empty", 32'(bus.o_empty), 32'(mq.size() == 0));
      chk("full", 32'(bus.o_full), 32'(mq.size() == DEPTH));
      chk("ready", 32'(bus.o_req_ready), 32'(mq.size() != DEPTH));
      chk("issue_valid", 32'(bus.o_issue_valid), 32'(e_valid));
      chk("issue_fields", {15'd0, bus.o_issue_wr, bus.o_issue_sel, bus.o_issue_addr, bus.o_issue_data},
          {15'd0, e_wr, e_sel, e_addr, e_data});
      chk("stall_cnt", 32'(bus.o_stall_cnt), 32'(e_stall));
    end
  end

  // Issue log seen at the DUT outputs: {wr, sel, addr, data}.
  logic [16:0] log_q[$];
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_issue_valid)
        log_q.push_back({bus.o_issue_wr, bus.o_issue_sel, bus.o_issue_addr, bus.o_issue_data});
    end
  end

  task automatic push(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    int n;
    n = 0;
    @(negedge clk); #1;
    bus.i_req_valid = 1'b1; bus.i_req_wr = wr; bus.i_req_addr = addr; bus.i_req_data = data;
    while (!bus.o_req_ready && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 200) chk("push_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.i_req_valid = 0; bus.i_req_wr = 0; bus.i_req_addr = 0; bus.i_req_data = 0;
    bus.i_bank_busy = 4'b0000;
    idle(2);
    chk("rst_empty", 32'(bus.o_empty), 32'd1);
    chk("rst_full", 32'(bus.o_full), 32'd0);
    chk("rst_ready", 32'(bus.o_req_ready), 32'd1);
    chk("rst_count", 32'(bus.o_count), 32'd0);
    chk("rst_valid", 32'(bus.o_issue_valid), 32'd0);
    chk("rst_stall", 32'(bus.o_stall_cnt), 32'd0);
    #2 rst_n = 1'b1;
    idle(2);

    // Single write: pulse appears two edges after acceptance.
    log_q.delete();
    push(1'b1, 8'hC5, 8'h3A);
    @(negedge clk);
    chk("lat_not_early", 32'(bus.o_issue_valid), 32'd0);
    @(negedge clk);
    chk("lat_pulse", 32'(bus.o_issue_valid), 32'd1);
    chk("lat_fields", {15'd0, bus.o_issue_wr, bus.o_issue_sel, bus.o_issue_addr, bus.o_issue_data},
        {15'd0, 1'b1, 2'b11, 6'h05, 8'h3A});
    chk("lat_count", 32'(bus.o_count), 32'd0);
    idle(3);
    chk("single_pulses", 32'(log_q.size()), 32'd1);

    // Fill while all banks busy, overflow attempt, then drain in order.
    bus.i_bank_busy = 4'b1111;
    push(1'b0, 8'h12, 8'h11);
    push(1'b1, 8'h47, 8'h22);
    push(1'b0, 8'h8A, 8'h33);
    push(1'b1, 8'hFF, 8'h44);
    chk("fill_full", 32'(bus.o_full), 32'd1);
    chk("fill_ready", 32'(bus.o_req_ready), 32'd0);
    @(negedge clk); #1;
    bus.i_req_valid = 1'b1; bus.i_req_wr = 1'b0; bus.i_req_addr = 8'h33; bus.i_req_data = 8'h55;
    idle(3);
    bus.i_req_valid = 1'b0;
    chk("overflow_count", 32'(bus.o_count), 32'd4);
    log_q.delete();
    bus.i_bank_busy = 4'b0000;
    idle(8);
    chk("drain_n", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      chk("drain0", 32'(log_q[0]), 32'({1'b0, 2'b00, 6'h12, 8'h11}));
      chk("drain1", 32'(log_q[1]), 32'({1'b1, 2'b01, 6'h07, 8'h22}));
      chk("drain2", 32'(log_q[2]), 32'({1'b0, 2'b10, 6'h0A, 8'h33}));
      chk("drain3", 32'(log_q[3]), 32'({1'b1, 2'b11, 6'h3F, 8'h44}));
    end
    chk("drain_count", 32'(bus.o_count), 32'd0);

    // Head-of-line blocking: bank 2 head holds back a bank 0 request.
    log_q.delete();
    bus.i_bank_busy = 4'b0100;
    push(1'b1, 8'hA9, 8'h66);
    push(1'b0, 8'h0C, 8'h77);
    n = 0;
    while (bus.o_stall_cnt != 8'd10 && n < 100) begin
      @(negedge clk); n++;
    end
    #1;
    chk("hol_stall10", 32'(bus.o_stall_cnt), 32'd10);
    chk("hol_no_issue", 32'(log_q.size()), 32'd0);
    bus.i_bank_busy = 4'b0000;
    @(negedge clk);
    chk("hol_stall_clr", 32'(bus.o_stall_cnt), 32'd0);
    idle(4);
    chk("hol_n", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("hol_first", 32'(log_q[0]), 32'({1'b1, 2'b10, 6'h29, 8'h66}));
      chk("hol_second", 32'(log_q[1]), 32'({1'b0, 2'b00, 6'h0C, 8'h77}));
    end

    // Stall counter saturation.
    bus.i_bank_busy = 4'b0010;
    push(1'b0, 8'h40, 8'h99);
    idle(300);
    chk("stall_sat", 32'(bus.o_stall_cnt), 32'd255);
    bus.i_bank_busy = 4'b0000;
    idle(3);

    // Back-to-back stream through the pointers.
    log_q.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      bus.i_req_valid = 1'b1; bus.i_req_wr = i[0];
      bus.i_req_addr = {i[1:0], 6'(i)}; bus.i_req_data = 8'hA0 + 8'(i);
      if (i == 6) chk("stream_count", 32'(bus.o_count), 32'd1);
    end
    @(negedge clk); #1;
    bus.i_req_valid = 1'b0;
    idle(4);
    chk("stream_n", 32'(log_q.size()), 32'd12);
    if (log_q.size() == 12) begin
      for (int i = 0; i < 12; i++)
        chk("stream_entry", 32'(log_q[i]), 32'({i[0], i[1:0], 6'(i), 8'hA0 + 8'(i)}));
    end

    // Asynchronous reset mid-cycle with entries queued and a pulse in flight.
    bus.i_bank_busy = 4'b1000;
    push(1'b0, 8'hC1, 8'h01);
    push(1'b1, 8'hD2, 8'h02);
    push(1'b0, 8'hE3, 8'h03);
    @(negedge clk); #1;
    bus.i_bank_busy = 4'b0000;
    @(posedge clk); #2;
    chk("pre_rst_valid", 32'(bus.o_issue_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.o_count), 32'd0);
    chk("arst_valid", 32'(bus.o_issue_valid), 32'd0);
    chk("arst_empty", 32'(bus.o_empty), 32'd1);
    log_q.delete();
    @(negedge clk); #2;
    rst_n = 1'b1;
    push(1'b0, 8'h9B, 8'h88);
    idle(4);
    chk("post_rst_n", 32'(log_q.size()), 32'd1);
    if (log_q.size() == 1)
      chk("post_rst_entry", 32'(log_q[0]), 32'({1'b0, 2'b10, 6'h1B, 8'h88}));
    chk("post_rst_count", 32'(bus.o_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/bank_request_queue.md
Name: bank_request_queue

Overview:
- Buffers incoming memory requests (read/write, address, data) in a small in-order FIFO ahead of the bank-routing logic.
- Issues one request per cycle to the four-bank array. It decodes the bank from the top two address bits and drives the select, local address and data that feed the address/data demultiplexers.
- Holds the head request while its target bank reports busy (head-of-line blocking, strictly in order).

Parameters:
- DATA_WIDTH, 8, width of write data.
- ADDR_WIDTH, 8, full request address width. Bits [ADDR_WIDTH-1:ADDR_WIDTH-2] select the bank; the remaining bits form the in-bank address.
- DEPTH, 4, FIFO entries. Must be a power of 2 and at least 2.
- CNT_WIDTH, 3, width of o_count. Must equal log2(DEPTH)+1.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_req_valid  input  1  upstream request present.
- o_req_ready  output  1  queue can accept; equals !o_full.
- i_req_wr  input  1  1 = write, 0 = read.
- i_req_addr  input  ADDR_WIDTH  full request address.
- i_req_data  input  DATA_WIDTH  write data; stored for reads but ignored downstream.
- i_bank_busy  input  4  per-bank busy; bit n high blocks issue to bank n.
- o_issue_valid  output  1  one-cycle pulse per issued request.
- o_issue_sel  output  2  bank select of the issued request; feeds demux select.
- o_issue_addr  output  ADDR_WIDTH-2  in-bank address.
- o_issue_data  output  DATA_WIDTH  write data.
- o_issue_wr  output  1  write/read of the issued request.
- o_count  output  CNT_WIDTH  current FIFO occupancy.
- o_full  output  1  o_count == DEPTH.
- o_empty  output  1  o_count == 0.
- o_stall_cnt  output  8  saturating count of cycles the current head has been blocked.

Behaviour:
- Reset (i_rst_n low, async):
  - Read/write pointers = 0, o_count = 0.
  - o_empty = 1, o_full = 0, o_req_ready = 1.
  - o_issue_valid = 0; o_issue_sel, o_issue_addr, o_issue_data, o_issue_wr = 0.
  - o_stall_cnt = 0.
  - FIFO storage is not reset.
- Reset asserted mid-operation discards all queued entries immediately. An o_issue_valid pulse in flight is dropped.
- Push:
  - Occurs at an edge where i_req_valid && o_req_ready.
  - Stores {wr, addr, data} at the write pointer; write pointer increments modulo DEPTH.
  - i_req_valid while full is ignored. Upstream must hold the request stable until ready.
- Head bank: hsel = stored addr[ADDR_WIDTH-1:ADDR_WIDTH-2] of the entry at the read pointer.
- Fire condition (combinational): !o_empty && !i_bank_busy[hsel].
- On fire at edge E:
  - Read pointer increments modulo DEPTH.
  - o_issue_valid = 1 for the cycle after E.
  - o_issue_sel = hsel, o_issue_addr = stored addr[ADDR_WIDTH-3:0], o_issue_data and o_issue_wr from the entry.
- No fire at edge E: o_issue_valid = 0 after E; the other issue outputs hold their last values.
- Latency: a request pushed at edge E0 into an empty queue with its bank free pulses o_issue_valid in the cycle after E1 (two edges). There is no bypass path.
- Simultaneous push and pop: o_count is unchanged.
  - When full, o_req_ready is already 0, so no push occurs even if a pop happens that edge.
  - When empty, a push never pops in the same edge.
- Pointer wrap: both pointers wrap DEPTH-1 -> 0. Occupancy comes from o_count, not from pointer comparison.
- o_stall_cnt:
  - Increments (saturating at 255) at each edge where !o_empty and i_bank_busy[hsel] is high.
  - Clears to 0 on fire.
  - Holds while empty.
- Busy bits of non-head banks have no effect. There is no reordering.

Test Plan:
- Reset then idle -> o_empty=1, o_full=0, o_req_ready=1, o_count=0, o_issue_valid=0, o_stall_cnt=0.
- Single write, addr=8'hC5, data=8'h3A, all banks free -> exactly one o_issue_valid pulse two edges after accept, with sel=2'b11, addr=6'h05, data=8'h3A, wr=1; o_count returns to 0.
- i_bank_busy=4'b1111, push 4 requests -> o_full=1, o_req_ready=0 after the 4th. A 5th i_req_valid is not stored. Release busy -> 4 pulses on consecutive cycles in push order, final o_count=0.
- Head targets bank 2 with i_bank_busy[2]=1 for 10 cycles; the second entry targets free bank 0 -> no issue during those 10 cycles (o_stall_cnt reaches 10). Bank-2 request issues first, then bank 0; o_stall_cnt clears on the first issue.
- Continuous push/pop stream of 12 requests through DEPTH=4, all banks free -> pointers wrap at least twice, outputs in order, no drops or duplicates, o_count steady at 1 in the steady state.
- Assert i_rst_n low asynchronously (mid-cycle) with 3 entries queued -> o_count=0, o_issue_valid=0 immediately. After release, new requests issue normally with no stale entries.
